// File: rtl/psum_store_pkg.sv
// Shared types and default sizing for the partial-sum store and its arbiter.
package psum_store_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int N_PE_DEF    = 4;
  localparam int I_WIDTH_DEF = 4;
  localparam int D_WIDTH_DEF = 16;
  localparam int W           = 2 * D_WIDTH_DEF;

endpackage

// File: rtl/psum_store_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, search starts at a
// registered pointer that moves just past the last winner.
module psum_store_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         m_clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            cand;

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    ptr_d = ptr_q;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr_q) + off) % N;
      if (!valid && req[cand]) begin
        gnt[cand] = 1'b1;
        valid     = 1'b1;
        ptr_d     = PW'((cand + 1) % N);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge m_clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psum_store.sv
// Partial-sum store: per-index accumulators shared by N_PE process units via a
// round-robin arbiter, with a low-priority drain port and a bulk clear.
module psum_store
  import psum_store_pkg::*;
#(
  parameter int N_PE    = N_PE_DEF,
  parameter int I_WIDTH = I_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic                      m_clk,
  input  logic                      rst,
  input  logic [N_PE-1:0]           rd_req,
  input  logic [N_PE-1:0]           wr_req,
  input  logic [N_PE*I_WIDTH-1:0]   idx_in,
  input  logic [N_PE*2*D_WIDTH-1:0] wdata_in,
  output logic [N_PE*2*D_WIDTH-1:0] rdata_out,
  output logic [N_PE-1:0]           rd_ack,
  output logic [N_PE-1:0]           wr_ack,
  input  logic                      drain_req,
  input  logic [I_WIDTH-1:0]        drain_idx,
  output logic [2*D_WIDTH-1:0]      drain_data,
  output logic                      drain_ack,
  input  logic                      clr,
  output logic                      busy
);

  localparam int DEPTH   = 2 ** I_WIDTH;
  localparam int ENTRY_W = 2 * D_WIDTH;

  state_e               state_q, state_d;
  logic [I_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];
  logic [N_PE-1:0]      rd_ack_q, rd_ack_d;
  logic [N_PE-1:0]      wr_ack_q, wr_ack_d;
  logic [ENTRY_W-1:0]   rdata_q [N_PE];
  logic [ENTRY_W-1:0]   rdata_d [N_PE];
  logic                 drain_ack_q, drain_ack_d;
  logic [ENTRY_W-1:0]   drain_data_q, drain_data_d;
  logic                 busy_q, busy_d;

  logic [N_PE-1:0]      eligible;
  logic [N_PE-1:0]      arb_req;
  logic [N_PE-1:0]      gnt;
  logic                 gnt_valid;
  logic [I_WIDTH-1:0]   sel_idx;

  // A PE still holding its request in its ack cycle is masked out so it is
  // not served twice; clr and the clear phase starve the arbiter entirely.
  assign eligible = (rd_req | wr_req) & ~rd_ack_q & ~wr_ack_q;
  assign arb_req  = (state_q == SERVE && !clr) ? eligible : '0;

  psum_store_rr_arbiter #(.N(N_PE)) u_arb (
    .m_clk (m_clk),
    .rst   (rst),
    .req   (arb_req),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_d        = mem_q;
    rd_ack_d     = '0;
    wr_ack_d     = '0;
    rdata_d      = rdata_q;
    drain_ack_d  = 1'b0;
    drain_data_d = drain_data_q;
    busy_d       = 1'b0;
    sel_idx      = '0;

    case (state_q)
      SERVE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (gnt_valid) begin
          for (int i = 0; i < N_PE; i++) begin
            if (gnt[i]) begin
              sel_idx = idx_in[i*I_WIDTH +: I_WIDTH];
              // A write beats the same PE's pending read; the read waits for
              // its next grant and then sees the new data.
              if (wr_req[i]) begin
                mem_d[sel_idx] = wdata_in[i*ENTRY_W +: ENTRY_W];
                wr_ack_d[i]    = 1'b1;
              end else begin
                rdata_d[i]  = mem_q[sel_idx];
                rd_ack_d[i] = 1'b1;
              end
            end
          end
        end else if (drain_req && !drain_ack_q) begin
          drain_data_d = mem_q[drain_idx];
          drain_ack_d  = 1'b1;
        end
      end

      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + I_WIDTH'(1);
        if (cnt_q == I_WIDTH'(DEPTH - 1)) state_d = SERVE;
        else                              busy_d  = 1'b1;
      end

      default: state_d = SERVE;
    endcase
  end

  // NOTE: the store is a plain register array rather than an SRAM macro, so
  // resetting every entry is legal and gives a known all-zero image.
  always_ff @(posedge m_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SERVE;
      cnt_q        <= '0;
      rd_ack_q     <= '0;
      wr_ack_q     <= '0;
      drain_ack_q  <= 1'b0;
      drain_data_q <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i]   <= '0;
      for (int i = 0; i < N_PE; i++)  rdata_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      rd_ack_q     <= rd_ack_d;
      wr_ack_q     <= wr_ack_d;
      rdata_q      <= rdata_d;
      drain_ack_q  <= drain_ack_d;
      drain_data_q <= drain_data_d;
      busy_q       <= busy_d;
    end
  end

  for (genvar g = 0; g < N_PE; g++) begin : g_rdata
    assign rdata_out[g*ENTRY_W +: ENTRY_W] = rdata_q[g];
  end

  assign rd_ack     = rd_ack_q;
  assign wr_ack     = wr_ack_q;
  assign drain_ack  = drain_ack_q;
  assign drain_data = drain_data_q;
  assign busy       = busy_q;

endmodule

// File: doc/psum_store.md
# psum_store

Shared partial-sum store for the MAC array: the responder side of the process units' destination read/modify/write traffic. It holds one 2*D_WIDTH-bit accumulator per weight index. It serves read and write requests from N_PE process units through a round-robin arbiter, one access per cycle. It also offers a low-priority drain port for the output stage and a bulk clear between layers.

## Interface
- N_PE, 4, number of process-unit ports
- I_WIDTH, 4, index width; DEPTH = 2**I_WIDTH entries
- D_WIDTH, 16, operand width; entry width W = 2*D_WIDTH
- m_clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rd_req  in  N_PE  per-PE read request, level, held until rd_ack
- wr_req  in  N_PE  per-PE write request, level, held until wr_ack
- idx_in  in  N_PE*I_WIDTH  per-PE entry index, slice i = PE i
- wdata_in  in  N_PE*W  per-PE write data
- rdata_out  out  N_PE*W  per-PE read data, valid with rd_ack
- rd_ack  out  N_PE  one-cycle read completion pulse
- wr_ack  out  N_PE  one-cycle write completion pulse
- drain_req  in  1  output-stage read request, level, held until drain_ack
- drain_idx  in  I_WIDTH  drain entry index
- drain_data  out  W  drain read data, valid with drain_ack
- drain_ack  out  1  one-cycle drain completion pulse
- clr  in  1  start bulk clear (pulse)
- busy  out  1  high while clearing

## Operation
- State machine with states SERVE and CLEAR. Reset enters SERVE.
- SERVE:
  - Eligible PE i = (rd_req[i] | wr_req[i]) & ~rd_ack[i] & ~wr_ack[i]. The ack mask prevents double service of a request still high in its ack cycle.
  - The round-robin arbiter picks one eligible PE per cycle, starting search at ptr. ptr <= granted+1 mod N_PE. ptr holds when nothing is granted.
  - Granted PE with wr_req set: mem[idx] <= wdata, wr_ack[i] pulses. The write wins over the same PE's rd_req that cycle; the read is served on a later grant.
  - Granted PE with rd_req only: rdata_out slice i <= mem[idx], rd_ack[i] pulses.
  - Drain is served only in a cycle with no eligible PE and drain_ack low. Action: drain_data <= mem[drain_idx], drain_ack pulses.
  - clr sampled high moves the block to CLEAR. This takes precedence over all grants that cycle.
- CLEAR:
  - Counter runs 0..DEPTH-1, writing 0 to mem[cnt] each cycle. busy = 1.
  - After entry DEPTH-1, return to SERVE.
  - No acks are issued; requests stay pending. clr is ignored.
- Width rule: stored data is exactly W bits. No arithmetic is done in this block.
- Index out of range cannot occur (DEPTH = 2**I_WIDTH).

## Timing
- All outputs are registered.
- Reset values:
  - rd_ack, wr_ack, drain_ack, busy = 0.
  - rdata_out, drain_data = 0.
  - All mem entries = 0, ptr = 0, cnt = 0, state SERVE.
- Latency: a request sampled and granted at edge k produces its ack/data visible after edge k (1 cycle). Under contention the wait is at most N_PE-1 extra cycles per PE.
- Ordering: a read granted at a later edge than a write to the same index returns the new data. No bypass is needed.
- rdata_out and drain_data hold their last value until the next grant to that port.
- Clear: clr at edge k gives busy high from k+1 through k+DEPTH; the first grant is possible at edge k+DEPTH+1.
- Reset mid-clear or mid-request: immediate return to the reset values; pending requests are lost and the requester retries.

## Structure
- Shared package holds:
  - the state enum {SERVE, CLEAR};
  - default N_PE, I_WIDTH, D_WIDTH constants;
  - localparam W.
- Sub-module rr_arbiter (N_PE-wide request vector in, one-hot grant + valid out, registered pointer).
- Memory is a register array here, so reset clear is legal.

## Test plan
- Reset, then PE0 reads idx 3 → rd_ack[0] one cycle later, data 0x00000000.
- PE1 writes 0x12345678 to idx 5, then PE2 reads idx 5 → wr_ack[1] then rd_ack[2] with 0x12345678.
- All 4 PEs assert wr_req on the same cycle with distinct indices → acks in order PE0, PE1, PE2, PE3, one per cycle. A second burst starts from the next ptr.
- PE3 holds rd_req and wr_req (idx 7, 0xAAAA5555) → wr_ack first, rd_ack on its next grant returns 0xAAAA5555. There is no duplicate ack while the request stays high in the ack cycle.
- Fill idx 0..15, pulse clr with PE0 rd_req pending → busy high 16 cycles, no acks. Then PE0 is acked with data 0, and a drain of idx 15 returns 0.
- drain_req while PE1 streams reads → drain_ack only in cycles with no eligible PE. Assert rst mid-stream → all acks drop immediately and all entries read 0 afterwards.
